// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-LED pattern generator for board bring-up. A prescaler divides sys_clk
// down to a step tick; each tick advances the pattern of the selected mode:
//   0 = binary count   (led = count, wraps at 2^NUM_LEDS)
//   1 = chase          (one-hot, rotates left, top bit wraps to bit 0)
//   2 = bounce         (single lit LED sweeping up and down, no dwell at ends)
//   3 = breathe        (all LEDs PWM-driven, duty ramps up and down per tick)
// The pattern can be paused. Output polarity is selectable so active-low
// board LEDs can be driven directly. Every output comes straight from a flop.
//
// Ports:
//   sys_clk  in   clock
//   sys_rst  in   synchronous reset, active-high
//   mode     in   [1:0] pattern select (see above)
//   pause    in   1 = freeze prescaler and pattern state (PWM keeps running)
//   tick     out  one-cycle step strobe, registered
//   led      out  [NUM_LEDS-1:0] registered LED drive, polarity per ACTIVE_LOW
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int CLK_HZ     = 27000000,
  parameter int TICK_HZ    = 10,
  parameter int NUM_LEDS   = 6,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  // A single LED still needs a 1-bit position register.
  localparam int POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  // XOR mask applied only at the output register; everything upstream is
  // active-high.
  localparam logic [NUM_LEDS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic                tick_q,      tick_d;
  mode_e               cur_mode_q,  cur_mode_d;
  logic [NUM_LEDS-1:0] count_q,     count_d;
  logic [NUM_LEDS-1:0] chase_q,     chase_d;
  logic [POS_W-1:0]    pos_q,       pos_d;
  // Shared by bounce and breathe; only one of them is ever active and a mode
  // change reinitialises it.
  logic                dir_up_q,    dir_up_d;
  logic [PWM_BITS-1:0] duty_q,      duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
  logic [NUM_LEDS-1:0] led_q,       led_d;

  logic                mode_change;
  logic                step;
  logic [NUM_LEDS-1:0] pattern;

  // ---------------------------------------------------------------------------
  // Active-high pattern from the current (registered) state. led is this one
  // cycle later, which gives the tick -> led latency of one clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so that
    // no path leaves it unassigned; an unassigned path would infer a latch.
    pattern = '0;
    unique case (cur_mode_q)
      MODE_COUNT:   pattern = count_q;
      MODE_CHASE:   pattern = chase_q;
      MODE_BOUNCE:  pattern = NUM_LEDS'(1) << pos_q;
      MODE_BREATHE: pattern = {NUM_LEDS{pwm_cnt_q < duty_q}};
      default:      pattern = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    prescaler_d = prescaler_q;
    tick_d      = 1'b0;
    cur_mode_d  = cur_mode_q;
    count_d     = count_q;
    chase_d     = chase_q;
    pos_d       = pos_q;
    dir_up_d    = dir_up_q;
    duty_d      = duty_q;
    // The PWM counter never stops, so a paused breathe holds its brightness.
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    led_d       = pattern ^ POL_MASK;
    step        = 1'b0;

    mode_change = (mode_e'(mode) != cur_mode_q);

    if (mode_change) begin
      // A mode switch wins over a coincident tick and over pause: restart the
      // prescaler and put the new mode at its initial pattern.
      cur_mode_d  = mode_e'(mode);
      prescaler_d = '0;
      count_d     = '0;
      chase_d     = NUM_LEDS'(1);
      pos_d       = '0;
      dir_up_d    = 1'b1;
      duty_d      = '0;
    end else if (!pause) begin
      if (prescaler_q == PRE_MAX) begin
        prescaler_d = '0;
        tick_d      = 1'b1;
        step        = 1'b1;
      end else begin
        prescaler_d = prescaler_q + PRE_W'(1);
      end
    end

    if (step) begin
      unique case (cur_mode_q)
        MODE_COUNT: begin
          count_d = count_q + NUM_LEDS'(1);
        end

        MODE_CHASE: begin
          // Rotate left; written as two shifts so NUM_LEDS == 1 degenerates
          // to "hold" without an out-of-range slice.
          chase_d = (chase_q << 1) | (chase_q >> (NUM_LEDS - 1));
        end

        MODE_BOUNCE: begin
          // Reverse at the ends by stepping straight to the neighbour, so the
          // end LEDs are lit for one step only.
          if (NUM_LEDS > 1) begin
            if (dir_up_q) begin
              if (pos_q == POS_MAX) begin
                dir_up_d = 1'b0;
                pos_d    = pos_q - POS_W'(1);
              end else begin
                pos_d    = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_up_d = 1'b1;
                pos_d    = pos_q + POS_W'(1);
              end else begin
                pos_d    = pos_q - POS_W'(1);
              end
            end
          end
        end

        MODE_BREATHE: begin
          // Triangle ramp 0 -> max -> 0, no dwell at either end.
          if (dir_up_q) begin
            if (duty_q == DUTY_MAX) begin
              dir_up_d = 1'b0;
              duty_d   = duty_q - PWM_BITS'(1);
            end else begin
              duty_d   = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              dir_up_d = 1'b1;
              duty_d   = duty_q + PWM_BITS'(1);
            end else begin
              duty_d   = duty_q - PWM_BITS'(1);
            end
          end
        end

        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers, synchronous reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of statement order.
    if (sys_rst) begin
      prescaler_q <= '0;
      tick_q      <= 1'b0;
      cur_mode_q  <= MODE_COUNT;
      count_q     <= '0;
      chase_q     <= NUM_LEDS'(1);
      pos_q       <= '0;
      dir_up_q    <= 1'b1;
      duty_q      <= '0;
      pwm_cnt_q   <= '0;
      led_q       <= POL_MASK;
    end else begin
      prescaler_q <= prescaler_d;
      tick_q      <= tick_d;
      cur_mode_q  <= cur_mode_d;
      count_q     <= count_d;
      chase_q     <= chase_d;
      pos_q       <= pos_d;
      dir_up_q    <= dir_up_d;
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule
